// File: rtl/m68040_bus_master.sv
// m68040_bus_master
//   FPGA-side 68040 bus initiator. Arbitrates for the bus with br/bg/bb, then
//   runs one single (byte/word/long) or 4-beat line cycle per request. Each
//   cycle is framed with ts/tip and terminated by ta/tea. The bus is always
//   released after a transfer (no parking).
//
//   Optional feature: define BUS_TIMEOUT_EN to enable a per-beat watchdog that
//   ends a cycle with err after TIMEOUT_CYCLES clocks without ta/tea. Without
//   the macro the DATA phase waits indefinitely.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req/req_rw/req_addr/req_siz/req_wdata
//                       request port; accepted when busy=0. req_wdata is passed
//                       straight to d_out, so the requester presents the next
//                       line word in the clock after each wnext pulse.
//   busy, wnext, rdata, rvalid, ack, err
//                       request status; wnext/rvalid/ack/err are 1-clk pulses
//   br, bg, bb_in, bb_out, bb_oe
//                       arbitration (all active-low on the bus)
//   a, a_oe, d_out, d_oe, d_in
//                       address / data buses
//   ts, tip, rw, siz, tt, tm
//                       cycle framing and attributes (ts/tip active-low)
//   ta, tea             transfer acknowledge / error (active-low)
//
// FSM states
//   state   | meaning
//   S_IDLE  | no request, bus not driven
//   S_ARB   | br asserted, waiting for bg=0 with bb_in=1
//   S_START | ts low for this single clock, address phase
//   S_DATA  | sampling ta/tea once per clock, counting beats
//   S_REL   | bb driven high for one clock, then all enables dropped

module m68040_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [2:0]  TM_VAL         = 3'b001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_siz,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        wnext,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        ack,
  output logic        err,
  output logic        br,
  input  logic        bg,
  input  logic        bb_in,
  output logic        bb_out,
  output logic        bb_oe,
  output logic [31:0] a,
  output logic        a_oe,
  output logic [31:0] d_out,
  output logic        d_oe,
  input  logic [31:0] d_in,
  output logic        ts,
  output logic        tip,
  output logic        rw,
  output logic [1:0]  siz,
  output logic [1:0]  tt,
  output logic [2:0]  tm,
  input  logic        ta,
  input  logic        tea
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_DATA,
    S_REL
  } state_t;

  localparam logic [1:0] SIZ_LINE = 2'b11;

  state_t     state;
  logic [1:0] beat;
  logic       retry_pend;
  logic       last_beat;

  assign tt    = 2'b00;
  assign tm    = TM_VAL;
  assign d_out = req_wdata;

  // Line transfers run four beats; every other size is a single beat.
  assign last_beat = (siz != SIZ_LINE) || (beat == 2'd3);

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  // Down-counter: reloaded on DATA entry and after every TA; expiry is the
  // clock on which it is already zero and still nothing has answered.
  logic [TW-1:0] tmo_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      beat       <= 2'd0;
      retry_pend <= 1'b0;
      busy       <= 1'b0;
      wnext      <= 1'b0;
      rdata      <= 32'd0;
      rvalid     <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
      br         <= 1'b1;
      bb_out     <= 1'b1;
      bb_oe      <= 1'b0;
      a          <= 32'd0;
      a_oe       <= 1'b0;
      d_oe       <= 1'b0;
      ts         <= 1'b1;
      tip        <= 1'b1;
      rw         <= 1'b1;
      siz        <= 2'b00;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt    <= TMO_LOAD;
`endif
    end else begin
      wnext  <= 1'b0;
      rvalid <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req && !busy) begin
            a     <= req_addr;
            rw    <= req_rw;
            siz   <= req_siz;
            busy  <= 1'b1;
            br    <= 1'b0;
            state <= S_ARB;
          end
        end

        S_ARB: begin
          // Grant and bus-not-busy must hold in the same sample.
          if (!bg && bb_in) begin
            bb_oe  <= 1'b1;
            bb_out <= 1'b0;
            a_oe   <= 1'b1;
            ts     <= 1'b0;
            tip    <= 1'b0;
            br     <= 1'b1;
            state  <= S_START;
          end
        end

        S_START: begin
          ts    <= 1'b1;
          beat  <= 2'd0;
          if (!rw) begin
            d_oe <= 1'b1;
          end
`ifdef BUS_TIMEOUT_EN
          tmo_cnt <= TMO_LOAD;
`endif
          state <= S_DATA;
        end

        S_DATA: begin
          if (!ta && tea) begin
            if (rw) begin
              rdata  <= d_in;
              rvalid <= 1'b1;
            end else begin
              wnext <= 1'b1;
            end
`ifdef BUS_TIMEOUT_EN
            tmo_cnt <= TMO_LOAD;
`endif
            if (last_beat) begin
              ack    <= 1'b1;
              tip    <= 1'b1;
              bb_out <= 1'b1;
              state  <= S_REL;
            end else begin
              beat <= beat + 2'd1;
            end
          end else if (ta && !tea) begin
            err    <= 1'b1;
            tip    <= 1'b1;
            bb_out <= 1'b1;
            state  <= S_REL;
          end else if (!ta && !tea) begin
            // Retry: give the bus back and rerun the same request from beat 0.
            retry_pend <= 1'b1;
            tip        <= 1'b1;
            bb_out     <= 1'b1;
            state      <= S_REL;
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            err    <= 1'b1;
            tip    <= 1'b1;
            bb_out <= 1'b1;
            state  <= S_REL;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end

        S_REL: begin
          bb_oe  <= 1'b0;
          bb_out <= 1'b1;
          a_oe   <= 1'b0;
          d_oe   <= 1'b0;
          if (retry_pend) begin
            retry_pend <= 1'b0;
            br         <= 1'b0;
            state      <= S_ARB;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68040_bus_master.sv
`timescale 1ns/1ps
module tb_m68040_bus_master;

  logic        clk;
  logic        rst;
  logic        req;
  logic        req_rw;
  logic [31:0] req_addr;
  logic [1:0]  req_siz;
  logic [31:0] req_wdata;
  logic        busy, wnext, rvalid, ack, err;
  logic [31:0] rdata;
  logic        br, bg, bb_in, bb_out, bb_oe;
  logic [31:0] a, d_out, d_in;
  logic        a_oe, d_oe;
  logic        ts, tip, rw;
  logic [1:0]  siz, tt;
  logic [2:0]  tm;
  logic        ta, tea;

  m68040_bus_master #(.TIMEOUT_CYCLES(16), .TM_VAL(3'b001)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_siz(req_siz), .req_wdata(req_wdata), .busy(busy), .wnext(wnext),
    .rdata(rdata), .rvalid(rvalid), .ack(ack), .err(err), .br(br), .bg(bg),
    .bb_in(bb_in), .bb_out(bb_out), .bb_oe(bb_oe), .a(a), .a_oe(a_oe),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in), .ts(ts), .tip(tip), .rw(rw),
    .siz(siz), .tt(tt), .tm(tm), .ta(ta), .tea(tea)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // scoreboard
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_resp[$];
  logic [31:0] wq[$];

  // trackers
  int          cyc, n_ts, n_rvalid, n_wnext, n_brreq, tip_bad, ts_cyc, end_cyc, acc_cyc;
  logic [31:0] ts_addr;
  logic [1:0]  ts_siz;
  logic        ts_rw;
  logic [4:0]  ts_attr;
  logic        ack_rv_same, rel_pending, bb_after, prev_br;
  logic [1:0]  bb_at_end;

  // bus environment
  int          grant_delay, gcnt, wait_cfg, wcnt, nbeats, beat;
  logic        in_xfer;
  logic [1:0]  plan [4];
  logic [31:0] plan_data [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [7:0] code;
    cyc++;
    if (rel_pending) begin
      bb_after    = bb_oe;
      rel_pending = 1'b0;
    end
    if (br === 1'b0 && prev_br === 1'b1) n_brreq++;
    prev_br = br;
    if (ts === 1'b0) begin
      n_ts++;
      ts_addr = a;
      ts_siz  = siz;
      ts_rw   = rw;
      ts_attr = {tt, tm};
      ts_cyc  = cyc;
    end
    if (in_xfer && tip !== 1'b0) tip_bad++;
    if (rvalid === 1'b1) begin
      n_rvalid++;
      if (exp_rd.size() == 0) check("rvalid_unexpected", 32'(rvalid), 32'd0);
      else check("rdata", rdata, exp_rd.pop_front());
    end
    if (wnext === 1'b1) begin
      n_wnext++;
      if (wq.size() > 0) req_wdata = wq.pop_front();
    end
    if (ack === 1'b1 || err === 1'b1) begin
      check("ack_err_exclusive", 32'(ack & err), 32'd0);
      code    = (ack === 1'b1) ? 8'h41 : 8'h45;
      end_cyc = cyc;
      if (ack === 1'b1 && rvalid === 1'b1) ack_rv_same = 1'b1;
      bb_at_end   = {bb_oe, bb_out};
      rel_pending = 1'b1;
      if (exp_resp.size() == 0) check("resp_unexpected", 32'({ack, err}), 32'd0);
      else check("resp", {24'd0, code}, {24'd0, exp_resp.pop_front()});
    end
  endtask

  task automatic drive();
    if (br === 1'b0) begin
      if (gcnt > 0) begin
        gcnt--;
        bg = 1'b1;
      end else begin
        bg = 1'b0;
      end
    end else begin
      bg   = 1'b1;
      gcnt = grant_delay;
    end
    bb_in = (bb_oe === 1'b1) ? bb_out : 1'b1;

    if (ts === 1'b0) begin
      in_xfer = 1'b1;
      beat    = 0;
      wcnt    = wait_cfg;
      ta      = 1'b1;
      tea     = 1'b1;
    end else if (in_xfer) begin
      if (wcnt > 0) begin
        wcnt--;
        ta  = 1'b1;
        tea = 1'b1;
      end else begin
        case (plan[beat])
          2'd0: begin
            ta   = 1'b0;
            tea  = 1'b1;
            d_in = plan_data[beat];
            if (rw === 1'b0) begin
              check("d_oe_beat", 32'(d_oe), 32'd1);
              check("d_out_beat", d_out, plan_data[beat]);
            end
            if (beat == nbeats - 1) in_xfer = 1'b0;
            else begin
              beat++;
              wcnt = wait_cfg;
            end
          end
          2'd1: begin
            ta      = 1'b1;
            tea     = 1'b0;
            in_xfer = 1'b0;
          end
          2'd2: begin
            ta         = 1'b0;
            tea        = 1'b0;
            in_xfer    = 1'b0;
            plan[beat] = 2'd0;
          end
          default: begin
            ta  = 1'b1;
            tea = 1'b1;
          end
        endcase
      end
    end else begin
      ta  = 1'b1;
      tea = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
    #1;
    drive();
  endtask

  task automatic prep();
    n_ts = 0; n_rvalid = 0; n_wnext = 0; n_brreq = 0; tip_bad = 0;
    ack_rv_same = 1'b0; rel_pending = 1'b0; bb_after = 1'b1; bb_at_end = 2'b00;
    prev_br = 1'b1; end_cyc = -1; ts_cyc = -1;
  endtask

  task automatic set_plan(input logic [1:0] p0, p1, p2, p3,
                          input logic [31:0] d0, d1, d2, d3, input int nb);
    plan[0] = p0; plan[1] = p1; plan[2] = p2; plan[3] = p3;
    plan_data[0] = d0; plan_data[1] = d1; plan_data[2] = d2; plan_data[3] = d3;
    nbeats = nb;
  endtask

  task automatic issue(input logic r, input logic [31:0] ad, input logic [1:0] sz, input logic [31:0] wd);
    req_rw = r; req_addr = ad; req_siz = sz; req_wdata = wd;
    req  = 1'b1;
    gcnt = grant_delay;
    step();
    acc_cyc = cyc;
    req = 1'b0;
    check("busy_after_req", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (busy === 1'b1 && n < max) begin
      step();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    step();
  endtask

  task automatic clear_env();
    req = 1'b0; bg = 1'b1; bb_in = 1'b1; ta = 1'b1; tea = 1'b1; d_in = 32'd0;
    in_xfer = 1'b0;
    exp_rd.delete(); exp_resp.delete(); wq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    req_rw = 1'b1; req_addr = 32'd0; req_siz = 2'b00; req_wdata = 32'd0;
    cyc = 0; grant_delay = 0; gcnt = 0; wait_cfg = 0; wcnt = 0; nbeats = 1; beat = 0;
    clear_env();
    set_plan(2'd0, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1);
    prep();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({br, bb_out, bb_oe, ts, tip, a_oe, d_oe, busy, wnext, rvalid, ack, err}), 32'hD80);
    rst = 1'b1;
    step();

    // Minimum latency: immediate grant, zero-wait TA.
    prep(); grant_delay = 0; wait_cfg = 0;
    set_plan(2'd0, 2'd0, 2'd0, 2'd0, 32'hCAFEF00D, 32'd0, 32'd0, 32'd0, 1);
    exp_rd.push_back(32'hCAFEF00D); exp_resp.push_back(8'h41);
    issue(1'b1, 32'h0000_0040, 2'b00, 32'd0);
    wait_done("lat_done", 50);
    check("min_latency", 32'(end_cyc - acc_cyc + 1), 32'd4);

    // Long read with delayed grant and 3 wait states.
    prep(); grant_delay = 2; wait_cfg = 3;
    set_plan(2'd0, 2'd0, 2'd0, 2'd0, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 1);
    exp_rd.push_back(32'hDEADBEEF); exp_resp.push_back(8'h41);
    issue(1'b1, 32'h3000_0010, 2'b00, 32'd0);
    wait_done("rd_done", 50);
    check("rd_ts_count", 32'(n_ts), 32'd1);
    check("rd_ts_addr", ts_addr, 32'h3000_0010);
    check("rd_attr_tt_tm", 32'(ts_attr), 32'h01);
    check("rd_rvalid_with_ack", 32'(ack_rv_same), 32'd1);
    check("rd_bb_at_ack", 32'(bb_at_end), 32'd3);
    check("rd_bb_released", 32'(bb_after), 32'd0);

    // Line write, four zero-wait TAs.
    prep(); grant_delay = 0; wait_cfg = 0;
    set_plan(2'd0, 2'd0, 2'd0, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4);
    wq.push_back(32'h22222222); wq.push_back(32'h33333333); wq.push_back(32'h44444444);
    exp_resp.push_back(8'h41);
    issue(1'b0, 32'h3000_0000, 2'b11, 32'h11111111);
    wait_done("lw_done", 50);
    check("lw_wnext_count", 32'(n_wnext), 32'd4);
    check("lw_tip_low", 32'(tip_bad), 32'd0);
    check("lw_ts_count", 32'(n_ts), 32'd1);
    check("lw_ts_siz", 32'(ts_siz), 32'd3);

    // Byte write into the FPGA region.
    prep(); grant_delay = 1; wait_cfg = 1;
    set_plan(2'd0, 2'd0, 2'd0, 2'd0, 32'h000000A5, 32'd0, 32'd0, 32'd0, 1);
    exp_resp.push_back(8'h41);
    issue(1'b0, 32'h8000_0003, 2'b01, 32'h000000A5);
    wait_done("bw_done", 50);
    check("bw_ts_addr", ts_addr, 32'h8000_0003);
    check("bw_ts_siz", 32'(ts_siz), 32'd1);
    check("bw_ts_rw", 32'(ts_rw), 32'd0);

    // Line read terminated by TEA on beat 2.
    prep(); grant_delay = 0; wait_cfg = 0;
    set_plan(2'd0, 2'd0, 2'd1, 2'd0, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 4);
    exp_rd.push_back(32'hA0A0A0A0); exp_rd.push_back(32'hA1A1A1A1); exp_resp.push_back(8'h45);
    issue(1'b1, 32'h3000_0100, 2'b11, 32'd0);
    wait_done("tea_done", 50);
    check("tea_rvalid_count", 32'(n_rvalid), 32'd2);
    check("tea_bus_released", 32'({bb_oe, a_oe, d_oe, br}), 32'd1);

    // Retry on first beat, then normal completion.
    prep(); grant_delay = 1; wait_cfg = 0;
    set_plan(2'd2, 2'd0, 2'd0, 2'd0, 32'h12345678, 32'd0, 32'd0, 32'd0, 1);
    exp_rd.push_back(32'h12345678); exp_resp.push_back(8'h41);
    issue(1'b1, 32'h0000_0100, 2'b00, 32'd0);
    wait_done("retry_done", 80);
    check("retry_ts_count", 32'(n_ts), 32'd2);
    check("retry_br_count", 32'(n_brreq), 32'd2);
    check("scoreboard_drained", 32'(exp_resp.size() + exp_rd.size()), 32'd0);

    // No responder at all.
    prep(); grant_delay = 0; wait_cfg = 0;
    set_plan(2'd3, 2'd3, 2'd3, 2'd3, 32'd0, 32'd0, 32'd0, 32'd0, 1);
`ifdef BUS_TIMEOUT_EN
    exp_resp.push_back(8'h45);
    issue(1'b1, 32'h2000_0000, 2'b00, 32'd0);
    wait_done("tmo_done", 100);
    check("tmo_err_time", 32'(end_cyc - ts_cyc), 32'd17);
    in_xfer = 1'b0;
`else
    begin
      int n_idle = 0;
      issue(1'b1, 32'h2000_0000, 2'b00, 32'd0);
      for (int i = 0; i < 1000; i++) begin
        step();
        if (busy !== 1'b1) n_idle++;
      end
      check("no_tmo_busy_held", 32'(n_idle), 32'd0);
    end
    rst = 1'b0;
    clear_env();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
`endif

    // Reset in the middle of a line write's DATA phase.
    prep(); grant_delay = 0; wait_cfg = 2;
    set_plan(2'd0, 2'd0, 2'd0, 2'd0, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 4);
    wq.push_back(32'h66666666); wq.push_back(32'h77777777); wq.push_back(32'h88888888);
    exp_resp.push_back(8'h41);
    issue(1'b0, 32'h3000_0200, 2'b11, 32'h55555555);
    begin
      int n = 0;
      while (n_wnext < 2 && n < 50) begin
        step();
        n++;
      end
    end
    check("pre_reset_wnext", 32'(n_wnext), 32'd2);
    check("pre_reset_d_oe", 32'(d_oe), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", 32'({br, bb_out, bb_oe, ts, tip, a_oe, d_oe, busy, wnext, rvalid, ack, err}), 32'hD80);
    clear_env();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    prep(); grant_delay = 0; wait_cfg = 0;
    set_plan(2'd0, 2'd0, 2'd0, 2'd0, 32'h9ABCDEF0, 32'd0, 32'd0, 32'd0, 1);
    exp_resp.push_back(8'h41);
    issue(1'b0, 32'h3000_0300, 2'b10, 32'h9ABCDEF0);
    wait_done("post_reset_done", 50);
    check("post_reset_ts_addr", ts_addr, 32'h3000_0300);
    check("final_drained", 32'(exp_resp.size() + exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
